// File: rtl/ram_loader_mar.sv
// SAP-1 memory address register plus byte loader that fills the 16x8 program RAM.
// Optional LOADER_CHECKSUM_EN adds ld_checksum, a running sum of accepted loader bytes.
module ram_loader_mar #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MI,
    input  logic              RI,
    input  logic              prog_mode,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              run_en,
    output logic [ADDR_W-1:0] ram_adress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_RW,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] ld_checksum,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              accept;

    // Handshake: a loader byte transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_data must be stable while ld_valid is high.
    // An abort (prog_mode low) in WAIT wins over a simultaneous transfer.
    assign accept = (state_q == ST_WAIT) && ld_valid && prog_mode;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        case (state_q)
            ST_RUN: begin
                if (MI) begin
                    mar_d = bus_in[ADDR_W-1:0];
                end
                if (prog_mode) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!prog_mode) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (accept) begin
                    byte_d  = ld_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The strobe for this cycle is already committed, so an abort
                // only prevents the next write.
                if (!prog_mode) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (!prog_mode) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            mar_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        ld_ready   = 1'b0;
        ld_done    = 1'b0;
        run_en     = 1'b0;
        ram_adress = cnt_q;
        ram_data   = byte_q;
        ram_RW     = 1'b1;
        case (state_q)
            ST_RUN: begin
                run_en     = 1'b1;
                ram_adress = mar_q;
                ram_data   = bus_in;
                ram_RW     = ~RI;
            end
            ST_WAIT:  ld_ready = 1'b1;
            ST_WRITE: ram_RW   = 1'b0;
            ST_DONE:  ld_done  = 1'b1;
            default: begin
                ld_ready = 1'b0;
            end
        endcase
    end

    assign dbg_state_o = state_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == ST_RUN && prog_mode) begin
            chk_d = '0;
        end else if (accept) begin
            chk_d = chk_q + ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign ld_checksum = chk_q;
`endif

endmodule

// File: tb/tb_ram_loader_mar.sv
// Directed bench for ram_loader_mar: MAR path, full/gapped/aborted loads, async reset.
module tb_ram_loader_mar;

    logic       clk;
    logic       rst;
    logic [7:0] bus_in;
    logic       MI;
    logic       RI;
    logic       prog_mode;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;
    logic       run_en;
    logic [3:0] ram_adress;
    logic [7:0] ram_data;
    logic       ram_RW;
    logic [1:0] dbg_state_o;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] ld_checksum;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {address, data} of every cycle the write strobe is low.
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];

    ram_loader_mar #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .MI         (MI),
        .RI         (RI),
        .prog_mode  (prog_mode),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .ld_done    (ld_done),
        .run_en     (run_en),
        .ram_adress (ram_adress),
        .ram_data   (ram_data),
        .ram_RW     (ram_RW),
`ifdef LOADER_CHECKSUM_EN
        .ld_checksum(ld_checksum),
`endif
        .dbg_state_o(dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && ram_RW === 1'b0) got_q.push_back({ram_adress, ram_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: offers bytes base, base+step, ... until n have been accepted.
    task automatic send_bytes(input int n, input logic [7:0] base, input logic [7:0] step,
                              input bit gaps, output int cycles);
        int sent;
        bit hs;
        sent = 0;
        cycles = 0;
        ld_data = base;
        ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        while (sent < n && cycles < 400) begin
            @(negedge clk);
            hs = ld_valid && ld_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (hs) begin
                sent++;
                ld_data = base + 8'(sent) * step;
            end
            if (gaps) begin
                ld_valid = 1'($urandom_range(0, 1));
                MI = 1'($urandom_range(0, 1));
                RI = 1'($urandom_range(0, 1));
                bus_in = 8'($urandom_range(0, 255));
            end
        end
        ld_valid = 1'b0;
        MI = 1'b0;
        RI = 1'b0;
        checks++;
        if (sent != n) begin
            errors++;
            $display("FAIL send_bytes_timeout accepted=%0d required=%0d", sent, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_in = 8'h00; MI = 1'b0; RI = 1'b0;
        prog_mode = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (ram_adress !== 4'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ram_adress); end
        checks++; if (ram_RW !== 1'b1) begin errors++; $display("FAIL reset_rw got=%b exp=1", ram_RW); end
        checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en got=%b exp=1", run_en); end
        checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
        checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_ld_done got=%b exp=0", ld_done); end
`ifdef LOADER_CHECKSUM_EN
        checks++; if (ld_checksum !== 8'h00) begin errors++; $display("FAIL reset_checksum got=%h exp=00", ld_checksum); end
`endif
    endtask

    task automatic test_mar();
        bus_in = 8'hA7; MI = 1'b1;
        tick();
        MI = 1'b0; bus_in = 8'h00;
        #1;
        checks++; if (ram_adress !== 4'h7) begin errors++; $display("FAIL mar_load got=%h exp=7", ram_adress); end
        RI = 1'b1; bus_in = 8'h3C;
        #1;
        checks++; if (ram_RW !== 1'b0) begin errors++; $display("FAIL mar_ri_rw got=%b exp=0", ram_RW); end
        checks++; if (ram_data !== 8'h3C) begin errors++; $display("FAIL mar_ri_data got=%h exp=3c", ram_data); end
        tick();
        RI = 1'b0;
        #1;
        checks++; if (ram_RW !== 1'b1) begin errors++; $display("FAIL mar_ri_release got=%b exp=1", ram_RW); end
        checks++; if (ram_adress !== 4'h7) begin errors++; $display("FAIL mar_hold got=%h exp=7", ram_adress); end
    endtask

    task automatic test_full_load();
        int cyc;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'h10 + 8'(i)});
        prog_mode = 1'b1;
        send_bytes(16, 8'h10, 8'h01, 1'b0, cyc);
        checks++; if (cyc != 32) begin errors++; $display("FAIL full_cycles got=%0d exp=32", cyc); end
        checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL full_done_early got=%b exp=0", ld_done); end
        checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL full_run_en_load got=%b exp=0", run_en); end
        checks++; if (ram_adress !== 4'hF || ram_RW !== 1'b0) begin errors++; $display("FAIL full_last_write addr=%h rw=%b exp=f/0", ram_adress, ram_RW); end
        tick();
        checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", ld_done); end
        checks++; if (ld_ready !== 1'b0 || ram_RW !== 1'b1) begin errors++; $display("FAIL full_done_outputs ready=%b rw=%b exp=0/1", ld_ready, ram_RW); end
        tick();
        checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL full_done_hold got=%b exp=1", ld_done); end
        prog_mode = 1'b0;
        tick();
        checks++; if (run_en !== 1'b1 || ld_done !== 1'b0) begin errors++; $display("FAIL full_back_to_run run_en=%b done=%b exp=1/0", run_en, ld_done); end
        checks++; if (ram_adress !== 4'h7) begin errors++; $display("FAIL full_mar_kept got=%h exp=7", ram_adress); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_gaps();
        int cyc;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 8'hA0 + 8'(i) * 8'h03});
        prog_mode = 1'b1;
        send_bytes(16, 8'hA0, 8'h03, 1'b1, cyc);
        tick();
        checks++; if (ld_done !== 1'b1) begin errors++; $display("FAIL gaps_done got=%b exp=1", ld_done); end
        prog_mode = 1'b0;
        tick();
        checks++; if (ram_adress !== 4'h7) begin errors++; $display("FAIL gaps_mar_unchanged got=%h exp=7", ram_adress); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL gaps_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int cyc;
        got_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({4'(i), 8'h40 + 8'(i)});
        prog_mode = 1'b1;
        send_bytes(5, 8'h40, 8'h01, 1'b0, cyc);
        prog_mode = 1'b0;
        #1;
        checks++; if (ram_RW !== 1'b0 || ram_adress !== 4'h4) begin errors++; $display("FAIL abort_inflight rw=%b addr=%h exp=0/4", ram_RW, ram_adress); end
        tick();
        checks++; if (run_en !== 1'b1 || ld_ready !== 1'b0) begin errors++; $display("FAIL abort_run run_en=%b ready=%b exp=1/0", run_en, ld_ready); end
        checks++; if (ram_adress !== 4'h7) begin errors++; $display("FAIL abort_mar got=%h exp=7", ram_adress); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        prog_mode = 1'b1;
        send_bytes(1, 8'h55, 8'h01, 1'b0, cyc);
        checks++; if (ram_adress !== 4'h0 || ram_data !== 8'h55) begin errors++; $display("FAIL reentry_first addr=%h data=%h exp=0/55", ram_adress, ram_data); end
        prog_mode = 1'b0;
        tick();
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL reentry_count got=%0d exp=1", got_q.size()); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        prog_mode = 1'b1;
        send_bytes(16, 8'hFF, 8'h00, 1'b0, cyc);
        tick();
        checks++; if (ld_checksum !== 8'hF0) begin errors++; $display("FAIL checksum_done got=%h exp=f0", ld_checksum); end
        prog_mode = 1'b0;
        tick();
        checks++; if (ld_checksum !== 8'hF0) begin errors++; $display("FAIL checksum_hold got=%h exp=f0", ld_checksum); end
    endtask
`endif

    task automatic test_mid_reset();
        int cyc;
        bus_in = 8'h0B; MI = 1'b1;
        tick();
        MI = 1'b0;
        prog_mode = 1'b1;
        send_bytes(2, 8'h20, 8'h01, 1'b0, cyc);
        #2 rst = 1'b1;
        #1;
        checks++; if (run_en !== 1'b1 || ram_adress !== 4'h0) begin errors++; $display("FAIL midrst_async run_en=%b addr=%h exp=1/0", run_en, ram_adress); end
        prog_mode = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (ld_ready !== 1'b0 || ld_done !== 1'b0 || ram_adress !== 4'h0) begin errors++; $display("FAIL midrst_idle ready=%b done=%b addr=%h exp=0/0/0", ld_ready, ld_done, ram_adress); end
    endtask

    initial begin
        test_reset();
        test_mar();
        test_full_load();
        test_gaps();
        test_abort();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
